// File: rtl/sys_read_return.sv
// Read-return mux: routes one outstanding read from the selected slave back to the MEM stage,
// with a timeout/illegal-select error path. Optional error counter under SYS_READ_RETURN_ERRCNT_EN.
module sys_read_return #(
  parameter int          W        = 32,
  parameter int          N        = 4,
  parameter int          SELW     = (N > 1) ? $clog2(N) : 1,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [SELW-1:0] req_sel,
  output logic            req_ready,
  input  logic [N-1:0]    slv_rvalid,
  input  logic [N*W-1:0]  slv_rdata,
  output logic            rd_valid,
  output logic [W-1:0]    rd_data,
  output logic            rd_err,
  output logic            busy
`ifdef SYS_READ_RETURN_ERRCNT_EN
  ,
  output logic [7:0]      err_count
`endif
);

  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] ERR_DATA = W'(ERR_WORD);

  typedef enum logic [1:0] {IDLE, WAIT, RESP_ERR} state_t;

  state_t          state, state_next;
  logic [SELW-1:0] sel;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    rdata_arr [N];
  logic            sel_legal;
  logic            accept;
  logic            hit;
  logic            expire;
  logic            resp_fire;
  logic            resp_err;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign rdata_arr[i] = slv_rdata[i*W +: W];
  end

  // A power-of-two slave count leaves no out-of-range select encodings.
  if ((1 << SELW) == N) begin : g_sel_full
    assign sel_legal = 1'b1;
  end else begin : g_sel_partial
    assign sel_legal = (req_sel < SELW'(N));
  end

  assign accept = req_valid && req_ready;
  assign hit    = slv_rvalid[sel];
  assign expire = (cnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = sel_legal ? WAIT : RESP_ERR;
        end
      end
      WAIT: begin
        if (hit || expire) begin
          state_next = IDLE;
        end
      end
      RESP_ERR: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Data beats timeout when both land in the same cycle, so resp_err requires !hit.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    resp_fire = ((state == WAIT) && (hit || expire)) || (state == RESP_ERR);
    resp_err  = (state == RESP_ERR) || ((state == WAIT) && !hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel <= '0;
      cnt <= '0;
    end else if (accept && sel_legal) begin
      sel <= req_sel;
      cnt <= '0;
    end else if ((state == WAIT) && !hit && !expire) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= resp_fire;
      if (resp_fire) begin
        rd_data <= resp_err ? ERR_DATA : rdata_arr[sel];
        rd_err  <= resp_err;
      end
    end
  end

`ifdef SYS_READ_RETURN_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (resp_fire && resp_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_sys_read_return.sv
// Testbench for sys_read_return: transaction-level model predicts response cycle, data and error
// from the chosen select and slave delay; five slaves so illegal selects are reachable.
module tb_sys_read_return;

  localparam int W       = 32;
  localparam int N       = 5;
  localparam int SELW    = 3;
  localparam int TIMEOUT = 15;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic [SELW-1:0] req_sel;
  logic            req_ready;
  logic [N-1:0]    slv_rvalid;
  logic [N*W-1:0]  slv_rdata;
  logic            rd_valid;
  logic [W-1:0]    rd_data;
  logic            rd_err;
  logic            busy;
`ifdef SYS_READ_RETURN_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  int          checks = 0;
  int          failures = 0;
  int          errs = 0;
  logic [31:0] lastData = '0;
  logic        lastErr = 1'b0;

  sys_read_return #(
    .W(W), .N(N), .SELW(SELW), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_sel(req_sel),
    .req_ready(req_ready),
    .slv_rvalid(slv_rvalid),
    .slv_rdata(slv_rdata),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_err(rd_err),
    .busy(busy)
`ifdef SYS_READ_RETURN_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Random traffic on every slave except the one carrying the scheduled response.
  task automatic driveSlaves(input int s, input bit ownValid, input bit ownDriven, input logic [31:0] data);
    for (int i = 0; i < N; i++) begin
      if (i == s && ownDriven) begin
        slv_rvalid[i] = ownValid;
        slv_rdata[i*W +: W] = ownValid ? data : $urandom;
      end else begin
        slv_rvalid[i] = 1'($urandom_range(0, 1));
        slv_rdata[i*W +: W] = $urandom;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      driveSlaves(-1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("idle_rd_valid", rd_valid, 1'b0);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_ready", req_ready, 1'b1);
      checkOutput("idle_hold_data", rd_data, lastData);
      checkOutput("idle_hold_err", rd_err, lastErr);
    end
  endtask

  // Called mid-cycle; that cycle is the request cycle. Selected slave answers in cycle d
  // after acceptance (d > TIMEOUT means it never answers in time).
  task automatic runTxn(input int s, input int d, input logic [31:0] data);
    int          r;
    bit          isErr;
    logic [31:0] expData;
    if (s >= N) begin
      r = 2; isErr = 1'b1;
    end else if (d <= TIMEOUT) begin
      r = d + 1; isErr = 1'b0;
    end else begin
      r = TIMEOUT + 1; isErr = 1'b1;
    end
    expData = isErr ? ERR : data;
    req_valid = 1'b1;
    req_sel = SELW'(s);
    driveSlaves(-1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("req_ready_on_request", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_sel = SELW'($urandom);
    for (int c = 1; c <= r; c++) begin
      driveSlaves(s, (c == d), (c < r), data);
      @(negedge clk);
      if (c < r) begin
        checkOutput("wait_rd_valid", rd_valid, 1'b0);
        checkOutput("wait_busy", busy, 1'b1);
        checkOutput("wait_ready", req_ready, 1'b0);
      end else begin
        if (isErr && errs < 255) errs++;
        checkOutput("resp_rd_valid", rd_valid, 1'b1);
        checkOutput("resp_rd_data", rd_data, expData);
        checkOutput("resp_rd_err", rd_err, isErr);
        checkOutput("resp_busy", busy, 1'b0);
        checkOutput("resp_ready", req_ready, 1'b1);
`ifdef SYS_READ_RETURN_ERRCNT_EN
        checkOutput("resp_err_count", err_count, errs);
`endif
        lastData = expData;
        lastErr = isErr;
      end
      if (c < r) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_sel = '0;
    slv_rvalid = '0;
    slv_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_rd_data", rd_data, 32'h0);
    checkOutput("reset_rd_err", rd_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ready", req_ready, 1'b1);
`ifdef SYS_READ_RETURN_ERRCNT_EN
    checkOutput("reset_err_count", err_count, 8'h00);
`endif
    rst_n = 1'b1;
    idleCycles(2);

    // Directed cases: fastest response, noisy neighbours, timeout, illegal selects.
    runTxn(0, 1, 32'h12345678);
    idleCycles(2);
    runTxn(2, 4, 32'h0000BEEF);
    idleCycles(1);
    runTxn(1, 100, 32'h0);
    idleCycles(1);
    runTxn(5, 1, 32'h0);
    idleCycles(1);
    runTxn(7, 3, 32'h0);
    idleCycles(1);

    // Back-to-back, then the data-versus-expiry boundary on either side.
    runTxn(0, 1, 32'h1);
    runTxn(0, 1, 32'h2);
    runTxn(4, TIMEOUT, 32'hCAFEF00D);
    runTxn(3, TIMEOUT + 1, 32'h55AA55AA);
    idleCycles(2);

    // Reset mid-WAIT abandons the request; a later slave valid must not produce a response.
    req_valid = 1'b1;
    req_sel = 3'd1;
    driveSlaves(1, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      driveSlaves(1, 1'b0, 1'b1, 32'h0);
      if (c == 3) rst_n = 1'b0;
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    errs = 0;
    lastData = '0;
    lastErr = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      driveSlaves(1, (c == 5), 1'b1, 32'h77777777);
      @(negedge clk);
      checkOutput("rst_abandon_rd_valid", rd_valid, 1'b0);
      checkOutput("rst_abandon_busy", busy, 1'b0);
      checkOutput("rst_abandon_ready", req_ready, 1'b1);
      checkOutput("rst_abandon_rd_data", rd_data, 32'h0);
`ifdef SYS_READ_RETURN_ERRCNT_EN
      checkOutput("rst_abandon_err_count", err_count, 8'h00);
`endif
      @(posedge clk); #1;
    end

    // Randomized transactions with random gaps or back-to-back issue.
    for (int t = 0; t < 40; t++) begin
      runTxn($urandom_range(0, 7), $urandom_range(1, TIMEOUT + 3), $urandom);
      if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
    end
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
